// File: rtl/uart_tx_serializer_pkg.sv
// rtl/uart_tx_serializer_pkg.sv - shared UART frame constants
package uart_tx_serializer_pkg;

    // Data bits per UART frame; shared with the TX FSM and parity calculator.
    localparam int UART_DATA_WIDTH = 8;

    typedef logic [UART_DATA_WIDTH-1:0] uart_word_t;

endpackage : uart_tx_serializer_pkg

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - TX FSM to serializer handshake bundle
interface uart_tx_serializer_if
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] data_in;
    logic                  load;
    logic                  enable;
    logic                  data_out;
    logic                  done;

    // TX FSM side: supplies the word and the load/advance strobes.
    modport master (
        output data_in,
        output load,
        output enable,
        input  data_out,
        input  done
    );

    // Serializer side.
    modport slave (
        input  data_in,
        input  load,
        input  enable,
        output data_out,
        output done
    );

endinterface : uart_tx_serializer_if

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - LSB-first parallel-to-serial converter for UART TX
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_serializer_if.slave   bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_reg_q;
    logic [DATA_WIDTH-1:0] shift_reg_d;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [CNT_W-1:0]      bit_cnt_d;
    logic                  last_bit;

    // The final bit saturates: further enables leave it on the line.
    assign last_bit     = (bit_cnt_q == LAST_CNT);
    assign bus.data_out = shift_reg_q[0];
    assign bus.done     = last_bit;

    // Next state: load restarts the word and beats enable; enable shifts until the MSB is out.
    always_comb begin
        shift_reg_d = shift_reg_q;
        bit_cnt_d   = bit_cnt_q;
        if (bus.load) begin
            shift_reg_d = bus.data_in;
            bit_cnt_d   = '0;
        end else if (bus.enable && !last_bit) begin
            shift_reg_d = {1'b0, shift_reg_q[DATA_WIDTH-1:1]};
            bit_cnt_d   = bit_cnt_q + CNT_W'(1);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg_q <= '0;
            bit_cnt_q   <= '0;
        end else begin
            shift_reg_q <= shift_reg_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

endmodule : uart_tx_serializer

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - randomized self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    uart_tx_serializer_if #(.DATA_WIDTH(W)) bus ();

    uart_tx_serializer #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: the loaded word plus how many bits have gone out.
    logic [W-1:0] m_word = '0;
    int           m_k    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        check("data_out", 32'(bus.data_out), 32'((m_word >> m_k) & 1));
        check("done", 32'(bus.done), 32'(m_k == W - 1));
    endtask

    // One clock: drive inputs, update the model at the edge, compare after it.
    task automatic step(input logic r, input logic ld, input logic en, input logic [W-1:0] din);
        rst         = r;
        bus.load    = ld;
        bus.enable  = en;
        bus.data_in = din;
        @(posedge clk);
        if (r) begin
            m_word = '0;
            m_k    = 0;
        end else if (ld) begin
            m_word = din;
            m_k    = 0;
        end else if (en && m_k < W - 1) begin
            m_k = m_k + 1;
        end
        #1;
        check_model();
    endtask

    initial begin
        logic [W-1:0] pat;

        rst         = 1'b1;
        bus.load    = 1'b0;
        bus.enable  = 1'b0;
        bus.data_in = '0;

        // Reset and idle
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);

        // Basic serialization of 0x55
        pat = 8'h55;
        step(1'b0, 1'b1, 1'b0, pat);
        check("basic_bit0", 32'(bus.data_out), 32'(pat[0]));
        for (int i = 1; i < W; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check("basic_bit", 32'(bus.data_out), 32'(pat[i]));
            check("basic_done", 32'(bus.done), 32'(i == W - 1));
        end

        // Stalled serialization of 0xA3
        step(1'b0, 1'b1, 1'b0, 8'hA3);
        for (int i = 0; i < 24; i++)
            step(1'b0, 1'b0, (i % 3) == 0, 8'h00);

        // Hold after done, then reload 0x01
        repeat (4) step(1'b0, 1'b0, 1'b1, 8'h00);
        check("hold_done", 32'(bus.done), 32'd1);
        check("hold_msb", 32'(bus.data_out), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'h01);
        check("reload01_done", 32'(bus.done), 32'd0);
        check("reload01_bit", 32'(bus.data_out), 32'd1);

        // Reload mid-word with enable high
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        repeat (3) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h00);
        check("midload_bit", 32'(bus.data_out), 32'd0);
        check("midload_done", 32'(bus.done), 32'd0);
        for (int i = 1; i < W; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check("midload_done_k", 32'(bus.done), 32'(i == W - 1));
        end

        // Reset mid-word
        step(1'b0, 1'b1, 1'b0, 8'hF0);
        repeat (5) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check("midrst_bit", 32'(bus.data_out), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'hC5);
        repeat (W - 1) step(1'b0, 1'b0, 1'b1, 8'h00);
        check("midrst_reload_done", 32'(bus.done), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 6), W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_tx_serializer
